// File: rtl/revaluate_controller_pkg.sv
// Shared types and constants for the revaluate controller.
// State encoding and 5x5 lane geometry.
package revaluate_controller_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    CALC = S_CALC,
    DONE = S_DONE
  } state_t;

  localparam int REVALUATE_DIM   = 5;
  localparam int REVALUATE_LANES = 25;

endpackage

// File: rtl/revaluate_controller.sv
// Sequencer for the 5x5 revaluate datapath: load, 25 shifts, done.
// Ports: clk, rst (async high), start, rowCntCo, colCntCo,
//   doneAck (only with REVALUATE_CTRL_DONE_HOLD_EN), busy, done,
//   ldReg, clrReg, rowCntEn, rowCntClr, colCntEn, colCntClr, shL, clrOut.
module revaluate_controller
  import revaluate_controller_pkg::*;
#(
  parameter int DIM = REVALUATE_DIM
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rowCntCo,
  input  logic colCntCo,
`ifdef REVALUATE_CTRL_DONE_HOLD_EN
  input  logic doneAck,
`endif
  output logic busy,
  output logic done,
  output logic ldReg,
  output logic clrReg,
  output logic rowCntEn,
  output logic rowCntClr,
  output logic colCntEn,
  output logic colCntClr,
  output logic shL,
  output logic clrOut
);

  if (DIM != REVALUATE_DIM) begin : g_dim_chk
    $error("revaluate_controller: only DIM=5 is supported");
  end

  state_t state;
  state_t nxt;
  logic   done_exit;

`ifdef REVALUATE_CTRL_DONE_HOLD_EN
  assign done_exit = doneAck;
`else
  assign done_exit = 1'b1;
`endif

  // Reserved: the input register is never cleared by this FSM.
  assign clrReg = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    busy      = 1'b0;
    done      = 1'b0;
    ldReg     = 1'b0;
    rowCntEn  = 1'b0;
    rowCntClr = 1'b0;
    colCntEn  = 1'b0;
    colCntClr = 1'b0;
    shL       = 1'b0;
    clrOut    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        ldReg     = 1'b1;
        rowCntClr = 1'b1;
        colCntClr = 1'b1;
        clrOut    = 1'b1;
        nxt       = CALC;
      end
      CALC: begin
        busy     = 1'b1;
        shL      = 1'b1;
        colCntEn = 1'b1;
        // Row steps on the same edge the column wraps.
        rowCntEn = colCntCo;
        if (rowCntCo && colCntCo) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (done_exit) nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_revaluate_controller.sv
// Bench for revaluate_controller with a behavioural 5x5 datapath.
// Table-driven passes plus reset, ignored-start and back-to-back sequences.
module tb_revaluate_controller;

  logic clk;
  logic rst;
  logic start;
  logic rowCntCo;
  logic colCntCo;
  logic doneAck;
  logic busy;
  logic done;
  logic ldReg;
  logic clrReg;
  logic rowCntEn;
  logic rowCntClr;
  logic colCntEn;
  logic colCntClr;
  logic shL;
  logic clrOut;

  revaluate_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rowCntCo  (rowCntCo),
    .colCntCo  (colCntCo),
`ifdef REVALUATE_CTRL_DONE_HOLD_EN
    .doneAck   (doneAck),
`endif
    .busy      (busy),
    .done      (done),
    .ldReg     (ldReg),
    .clrReg    (clrReg),
    .rowCntEn  (rowCntEn),
    .rowCntClr (rowCntClr),
    .colCntEn  (colCntEn),
    .colCntClr (colCntClr),
    .shL       (shL),
    .clrOut    (clrOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: in bit 24 is row 0 col 0 (row-major, MSB first).
  logic [24:0] din_v;
  logic [24:0] in_r;
  logic [24:0] dp_out;
  logic [2:0]  row;
  logic [2:0]  col;
  logic        bitv;

  assign rowCntCo = (row == 3'd4);
  assign colCntCo = (col == 3'd4);

  function automatic logic abit(input logic [24:0] a, input int r, input int c);
    int k;
    logic [24:0] t;
    k = r * 5 + c;
    t = a;
    return t[24 - k];
  endfunction

  always_comb begin
    int r;
    int c;
    bitv = 1'b0;
    r = int'(row);
    c = int'(col);
    if (r < 5 && c < 5)
      bitv = abit(in_r, r, c) ^
             (~abit(in_r, r, (c + 1) % 5) & abit(in_r, r, (c + 2) % 5));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_r   <= '0;
      dp_out <= '0;
      row    <= '0;
      col    <= '0;
    end else begin
      if (ldReg) in_r <= din_v;
      if (rowCntClr)     row <= '0;
      else if (rowCntEn) row <= (row == 3'd4) ? 3'd0 : row + 3'd1;
      if (colCntClr)     col <= '0;
      else if (colCntEn) col <= (col == 3'd4) ? 3'd0 : col + 3'd1;
      if (clrOut)   dp_out <= '0;
      else if (shL) dp_out <= {dp_out[23:0], bitv};
    end
  end

  logic [9:0] outs;
  assign outs = {busy, done, ldReg, clrReg, rowCntEn,
                 rowCntClr, colCntEn, colCntClr, shL, clrOut};

  localparam logic [9:0] V_LOAD = 10'b10_1001_0101;
  localparam logic [9:0] V_CALC = 10'b10_0000_1010;

  int n_tests;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int n_ld, ld_first, n_sh, sh_first, sh_last;
  int n_row, row_bad, n_busy, n_done, clr_seen;
  int done_at[4];
  logic [24:0] out_at_done;
  logic [9:0]  v_c1;
  logic [9:0]  v_c2;

  task automatic observe(input int ncyc, input bit hold,
                         input int p1, input int p2);
    n_ld = 0; ld_first = 0; n_sh = 0; sh_first = 0; sh_last = 0;
    n_row = 0; row_bad = 0; n_busy = 0; n_done = 0; clr_seen = 0;
    out_at_done = '0; v_c1 = '0; v_c2 = '0;
    for (int i = 0; i < 4; i++) done_at[i] = 0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (n == 1) v_c1 = outs;
      if (n == 2) v_c2 = outs;
      if (ldReg) begin
        n_ld++;
        if (ld_first == 0) ld_first = n;
      end
      if (shL) begin
        n_sh++;
        if (sh_first == 0) sh_first = n;
        sh_last = n;
      end
      if (rowCntEn) begin
        n_row++;
        if (n < 6 || (n - 1) % 5 != 0) row_bad++;
      end
      if (busy) n_busy++;
      if (clrReg) clr_seen = 1;
      if (done) begin
        if (n_done == 0) out_at_done = dp_out;
        if (n_done < 4) done_at[n_done] = n;
        n_done++;
      end
      start = hold || (n == p1) || (n == p2);
    end
  endtask

  task automatic launch(input logic [24:0] d);
    @(negedge clk);
    din_v = d;
    start = 1'b1;
    @(posedge clk);
  endtask

  typedef struct {
    logic [24:0] din;
    logic [24:0] dout;
  } vec_t;

  vec_t tv[3];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    doneAck = 1'b1;
    din_v   = '0;

    tv[0] = '{din: 25'h1FFFFFF, dout: 25'h1FFFFFF};
    tv[1] = '{din: 25'h0000000, dout: 25'h0000000};
    tv[2] = '{din: 25'h1000000, dout: 25'h1200000};

    repeat (2) @(negedge clk);
    chk("reset_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", 32'(outs), 32'h0);

    for (int i = 0; i < 3; i++) begin
      launch(tv[i].din);
      observe(40, 1'b0, 0, 0);
      chk($sformatf("v%0d_out", i), 32'(out_at_done), 32'(tv[i].dout));
      chk($sformatf("v%0d_done_cyc", i), done_at[0], 27);
      chk($sformatf("v%0d_done_cnt", i), n_done, 1);
      if (i == 0) begin
        chk("load_vec", 32'(v_c1), 32'(V_LOAD));
        chk("calc_vec", 32'(v_c2), 32'(V_CALC));
        chk("ld_cnt", n_ld, 1);
        chk("ld_cyc", ld_first, 1);
        chk("shl_cnt", n_sh, 25);
        chk("shl_span", sh_last - sh_first + 1, 25);
        chk("shl_first", sh_first, 2);
        chk("row_cnt", n_row, 5);
        chk("row_pos", row_bad, 0);
        chk("busy_cnt", n_busy, 26);
        chk("clrreg", clr_seen, 0);
      end
    end

    launch(25'h0ABCDEF);
    observe(40, 1'b0, 5, 20);
    chk("ign_done_cnt", n_done, 1);
    chk("ign_done_cyc", done_at[0], 27);
    chk("ign_ld_cnt", n_ld, 1);

    launch(25'h1FFFFFF);
    observe(10, 1'b0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", 32'(outs), 32'h0);
    @(negedge clk);
    chk("rst_hold_outs", 32'(outs), 32'h0);
    rst = 1'b0;
    observe(40, 1'b0, 0, 0);
    chk("rst_no_done", n_done, 0);
    chk("rst_no_busy", n_busy, 0);
    launch(tv[2].din);
    observe(40, 1'b0, 0, 0);
    chk("rst_fresh_cyc", done_at[0], 27);
    chk("rst_fresh_out", 32'(out_at_done), 32'(tv[2].dout));

    launch(tv[2].din);
    observe(90, 1'b1, 0, 0);
    start = 1'b0;
    chk("b2b_done0", done_at[0], 27);
    chk("b2b_done1", done_at[1], 55);
    chk("b2b_done2", done_at[2], 83);
    chk("b2b_done_cnt", n_done, 3);
    chk("b2b_out", 32'(out_at_done), 32'(tv[2].dout));
    repeat (40) @(negedge clk);

`ifdef REVALUATE_CTRL_DONE_HOLD_EN
    doneAck = 1'b0;
    launch(tv[0].din);
    observe(27, 1'b0, 0, 0);
    chk("hold_done_cyc", done_at[0], 27);
    for (int k = 0; k < 10; k++) begin
      start = 1'b1;
      @(negedge clk);
      chk($sformatf("hold_done_%0d", k), 32'(done), 32'h1);
      chk($sformatf("hold_busy_%0d", k), 32'(busy), 32'h0);
    end
    chk("hold_out", 32'(dp_out), 32'(tv[0].dout));
    doneAck = 1'b1;
    start   = 1'b0;
    @(negedge clk);
    chk("hold_ack_outs", 32'(outs), 32'h0);
    @(negedge clk);
    chk("hold_idle_outs", 32'(outs), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
